trig_conditioner: RTL and testbench

TRIG_CONDITIONER -- requirements
Module: trig_conditioner

---
 rtl/trig_conditioner.sv | 127 ++++++++++++
 tb/tb_trig_conditioner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/trig_conditioner.sv
`timescale 1ns/1ps
// Trigger conditioner: synchronizes and debounces a raw trigger pin, then gates a
// fixed-length run window followed by a hold-off, counting accepted and refused edges.
module trig_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16,
  parameter int RUN_CYCLES  = 201200,
  parameter int HOLDOFF     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig_in,
  input  logic        arm,
  output logic        trig_out,
  output logic        busy,
  output logic [15:0] shot_count,
  output logic [7:0]  missed_count
);

  localparam int MAX_CNT = (RUN_CYCLES > HOLDOFF) ? RUN_CYCLES : HOLDOFF;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT + 1) : 1;
  localparam int DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [CNT_W-1:0] RUN_LOAD  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLDOFF} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt;
  logic [DB_W-1:0]        db_cnt;
  logic                   rise;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [15:0]            shot_n;
  logic [7:0]             missed_n;

  // NOTE: the synchronizer chain is plain flops, so it is reset like everything
  // else; only true memory arrays are left without reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= 1'b0;
      db_cnt <= '0;
      rise   <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (synced == filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        filt   <= synced;
        db_cnt <= '0;
        rise   <= synced;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shot_n   = shot_count;
    missed_n = missed_count;
    unique case (state)
      S_IDLE: begin
        if (rise && arm) begin
          state_n = S_RUN;
          cnt_n   = RUN_LOAD;
          shot_n  = shot_count + 16'd1;
        end
      end
      S_RUN: begin
        if (cnt == '0) begin
          if (HOLDOFF > 0) begin
            state_n = S_HOLDOFF;
            cnt_n   = HOLD_LOAD;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    // Any edge that does not start a run is refused, saturating at full scale.
    if (rise && !(state == S_IDLE && arm) && missed_count != 8'hFF)
      missed_n = missed_count + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      trig_out     <= 1'b0;
      busy         <= 1'b0;
      shot_count   <= '0;
      missed_count <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      trig_out     <= (state_n == S_RUN);
      busy         <= (state_n != S_IDLE);
      shot_count   <= shot_n;
      missed_count <= missed_n;
    end
  end

endmodule

// File: tb/tb_trig_conditioner.sv
`timescale 1ns/1ps
// Directed bench for trig_conditioner: run/busy lengths are scoreboarded from a
// negedge monitor, counters and latencies are checked inline.
module tb_trig_conditioner;

  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE    = 4;
  localparam int RUN_CYCLES  = 20;
  localparam int HOLDOFF     = 5;
  localparam int LAT         = SYNC_STAGES + DEBOUNCE + 1;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        trig_in = 1'b0;
  logic        arm     = 1'b0;
  logic        trig_out;
  logic        busy;
  logic [15:0] shot_count;
  logic [7:0]  missed_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_run[$];
  int exp_busy[$];
  int hi_len   = 0;
  int busy_len = 0;

  always #5 clk = ~clk;

  trig_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE),
    .RUN_CYCLES (RUN_CYCLES),
    .HOLDOFF    (HOLDOFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig_in     (trig_in),
    .arm         (arm),
    .trig_out    (trig_out),
    .busy        (busy),
    .shot_count  (shot_count),
    .missed_count(missed_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    trig_in = 1'b1;
    tick(hi);
    trig_in = 1'b0;
    tick(lo);
  endtask

  task automatic expect_run();
    exp_run.push_back(RUN_CYCLES);
    exp_busy.push_back(RUN_CYCLES + HOLDOFF);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Measures each completed trig_out / busy window and compares it against the
  // oldest expectation; an unannounced window is compared against zero length.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hi_len   = 0;
        busy_len = 0;
      end else begin
        if (trig_out) hi_len++;
        else if (hi_len > 0) begin
          e = (exp_run.size() > 0) ? exp_run.pop_front() : 0;
          check("run_len", hi_len, e);
          hi_len = 0;
        end
        if (busy) busy_len++;
        else if (busy_len > 0) begin
          e = (exp_busy.size() > 0) ? exp_busy.pop_front() : 0;
          check("busy_len", busy_len, e);
          busy_len = 0;
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_trig_out", trig_out, 0);
    check("rst_busy", busy, 0);
    check("rst_shot", shot_count, 0);
    check("rst_missed", missed_count, 0);
    rst_n = 1'b1;
    arm   = 1'b1;
    tick(3);

    // Clean armed edge: latency, run and busy windows
    expect_run();
    trig_in = 1'b1;
    tick(LAT - 1);
    check("latency_pre", trig_out, 0);
    tick(1);
    check("latency_edge", trig_out, 1);
    check("busy_on_start", busy, 1);
    check("shot_on_start", shot_count, 1);
    tick(10);
    trig_in = 1'b0;
    tick(RUN_CYCLES + HOLDOFF);
    check("s1_busy", busy, 0);
    check("s1_shot", shot_count, 1);
    check("s1_missed", missed_count, 0);

    // Glitch shorter than the debounce window
    trig_in = 1'b1;
    tick(DEBOUNCE - 1);
    trig_in = 1'b0;
    tick(12);
    check("glitch_trig", trig_out, 0);
    check("glitch_shot", shot_count, 1);
    check("glitch_missed", missed_count, 0);

    // Edges during RUN and HOLDOFF are refused; arm drop mid-run is ignored
    do_reset();
    tick(2);
    expect_run();
    pulse(8, 5);
    pulse(6, 4);
    arm = 1'b0;
    check("mid_run_trig", trig_out, 1);
    pulse(6, 30);
    arm = 1'b1;
    check("busy_edges_shot", shot_count, 1);
    check("busy_edges_missed", missed_count, 2);
    check("busy_edges_idle", busy, 0);

    // Disarmed edges and saturation
    do_reset();
    arm = 1'b0;
    tick(2);
    pulse(8, 8);
    check("disarm_trig", trig_out, 0);
    check("disarm_missed1", missed_count, 1);
    check("disarm_shot", shot_count, 0);
    repeat (99) pulse(6, 6);
    check("disarm_missed100", missed_count, 100);
    repeat (200) pulse(6, 6);
    check("missed_saturate", missed_count, 255);
    check("disarm_busy", busy, 0);

    // Reset in the middle of a run with the trigger still held
    do_reset();
    arm = 1'b1;
    tick(2);
    trig_in = 1'b1;
    tick(LAT);
    check("pre_reset_run", trig_out, 1);
    tick(9);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_trig", trig_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_shot", shot_count, 0);
    check("async_rst_missed", missed_count, 0);
    tick(2);
    expect_run();
    rst_n = 1'b1;
    tick(LAT - 1);
    check("post_rst_pre", trig_out, 0);
    tick(1);
    check("post_rst_edge", trig_out, 1);
    check("post_rst_shot", shot_count, 1);
    tick(5);
    trig_in = 1'b0;
    tick(40);
    check("post_rst_idle", busy, 0);

    // Shot counter wrap from full scale
    #2 force dut.shot_count = 16'hFFFF;
    #1 release dut.shot_count;
    tick(1);
    expect_run();
    pulse(8, 40);
    check("shot_wrap", shot_count, 0);
    check("wrap_missed", missed_count, 0);

    for (int i = 0; i < 100 && (exp_run.size() + exp_busy.size()) > 0; i++) tick(1);
    check("scoreboard_drain", exp_run.size() + exp_busy.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
